// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults and word type for the 8-bit FIFO, the 2:1
//               valid-tagged mux and the demux stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Default geometry and flag thresholds
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_AF_TH      = 3;
  localparam int DEF_AE_TH      = 1;

  // Word carried through the FIFO / mux / demux datapath
  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : FIFO storage array. Synchronous write port, synchronous
//               read port, no reset (contents are don't-care after reset).
//               A read and a write to the same address on one edge return
//               the old word.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int c_depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port: store the incoming word at the write address
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read port: capture the addressed word; holds when no read is issued
  always_ff @(posedge clk) begin
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule : fifo_mem
`default_nettype wire

// File: rtl/fifo_8b.sv
`default_nettype none
// ============================================================================
// Module      : fifo_8b
// Description : Synchronous FIFO buffering one mux input channel. Provides
//               registered read data with a valid tag, occupancy flags
//               decoded from the registered count, and an overflow /
//               underflow error flag.
//               Build option FIFO_ERR_STICKY_EN: when defined, error is
//               sticky until reset; otherwise it is a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_8b
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_TH      = DEF_AF_TH,
  parameter int AE_TH      = DEF_AE_TH
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int                    c_depth_int = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   c_depth     = c_depth_int[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   c_af_th     = AF_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   c_ae_th     = AE_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one   = 1;
  localparam logic [ADDR_WIDTH:0]   c_cnt_one   = 1;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_valid;
  logic                  r_error;
  logic                  r_data_seen;

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_overflow;
  logic                  w_underflow;
  logic                  w_err_event;
  logic [DATA_WIDTH-1:0] w_mem_rd_data;

  // Flags come straight from the registered count: no push/pop feed-through
  assign full         = (r_count == c_depth);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= c_af_th);
  assign almost_empty = (r_count <= c_ae_th);

  // A push while full is still accepted when a pop frees a slot that edge.
  // A push into an empty FIFO never feeds a same-edge pop (no bypass).
  assign w_wr_ok     = push && (!full || pop);
  assign w_rd_ok     = pop && !empty;
  assign w_overflow  = push && full && !pop;
  assign w_underflow = pop && empty;
  assign w_err_event = w_overflow || w_underflow;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_wr_ok),
    .wr_addr (r_wr_ptr),
    .wr_data (data_in),
    .rd_en   (w_rd_ok),
    .rd_addr (r_rd_ptr),
    .rd_data (w_mem_rd_data)
  );

  // Pointers advance on accepted accesses and wrap naturally modulo DEPTH
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // Occupancy: +1 on write only, -1 on read only, hold otherwise
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_count <= '0;
    end else begin
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read tag: valid_out marks a word popped on the previous edge. The
  // storage read register has no reset, so r_data_seen masks data_out to
  // zero until the first read after reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_valid     <= 1'b0;
      r_data_seen <= 1'b0;
    end else begin
      r_valid <= w_rd_ok;
      if (w_rd_ok) r_data_seen <= 1'b1;
    end
  end

  assign valid_out = r_valid;
  assign data_out  = r_data_seen ? w_mem_rd_data : '0;

  // Error flag: sticky or single-cycle pulse depending on build option
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_error <= 1'b0;
    end else begin
`ifdef FIFO_ERR_STICKY_EN
      r_error <= r_error || w_err_event;
`else
      r_error <= w_err_event;
`endif
    end
  end

  assign error = r_error;

endmodule : fifo_8b
`default_nettype wire

// File: tb/tb_fifo_8b.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_8b
// Description : Directed self-checking bench for fifo_8b. Inputs change on
//               the falling edge; outputs are checked 1 time unit after the
//               rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_8b;

`ifdef FIFO_ERR_STICKY_EN
  localparam logic c_sticky = 1'b1;
`else
  localparam logic c_sticky = 1'b0;
`endif

  logic       clk;
  logic       reset_L;
  logic       push;
  logic [7:0] data_in;
  logic       pop;
  logic [7:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;

  int n_vec;
  int n_err;

  fifo_8b dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, return 1 unit after the rising edge
  task automatic cyc(input logic p, input logic [7:0] d, input logic q);
    @(negedge clk);
    push    = p;
    data_in = d;
    pop     = q;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic e, input logic ae,
                           input logic af, input logic f);
    chk({tag, ".empty"}, {7'd0, empty}, {7'd0, e});
    chk({tag, ".almost_empty"}, {7'd0, almost_empty}, {7'd0, ae});
    chk({tag, ".almost_full"}, {7'd0, almost_full}, {7'd0, af});
    chk({tag, ".full"}, {7'd0, full}, {7'd0, f});
  endtask

  initial begin
    logic [7:0] exp_word;
    n_vec   = 0;
    n_err   = 0;
    reset_L = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = 8'h00;

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.data_out", data_out, 8'h00);
    chk("rst.valid_out", {7'd0, valid_out}, 8'h00);
    chk("rst.error", {7'd0, error}, 8'h00);
    chk_flags("rst", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset_L = 1'b1;

    // ---- fill: thresholds on the way up (counts 1..4)
    cyc(1'b1, 8'hA1, 1'b0);
    chk_flags("cnt1", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("cnt1.valid_out", {7'd0, valid_out}, 8'h00);
    cyc(1'b1, 8'hB2, 1'b0);
    chk_flags("cnt2", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0);
    chk_flags("cnt3", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'hD4, 1'b0);
    chk_flags("cnt4", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("cnt4.error", {7'd0, error}, 8'h00);

    // ---- overflow: 0xEE dropped, error raised
    cyc(1'b1, 8'hEE, 1'b0);
    chk("ovf.error", {7'd0, error}, 8'h01);
    chk("ovf.full", {7'd0, full}, 8'h01);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf.error_after", {7'd0, error}, {7'd0, c_sticky});

    // ---- push + pop while full: oldest out, count stays 4, no new error
    cyc(1'b1, 8'h55, 1'b1);
    chk("fullpp.data_out", data_out, 8'hA1);
    chk("fullpp.valid_out", {7'd0, valid_out}, 8'h01);
    chk("fullpp.full", {7'd0, full}, 8'h01);
    chk("fullpp.error", {7'd0, error}, {7'd0, c_sticky});

    // ---- drain: B2, C3, D4, 55 (0xEE must not appear)
    cyc(1'b0, 8'h00, 1'b1);
    chk("drain1.data_out", data_out, 8'hB2);
    chk("drain1.valid_out", {7'd0, valid_out}, 8'h01);
    chk_flags("drain1", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("drain2.data_out", data_out, 8'hC3);
    chk("drain2.valid_out", {7'd0, valid_out}, 8'h01);
    chk_flags("drain2", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("drain3.data_out", data_out, 8'hD4);
    chk("drain3.valid_out", {7'd0, valid_out}, 8'h01);
    chk_flags("drain3", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("drain4.data_out", data_out, 8'h55);
    chk("drain4.valid_out", {7'd0, valid_out}, 8'h01);
    chk_flags("drain4", 1'b1, 1'b1, 1'b0, 1'b0);

    // ---- idle: valid drops, data_out holds
    cyc(1'b0, 8'h00, 1'b0);
    chk("idle.valid_out", {7'd0, valid_out}, 8'h00);
    chk("idle.data_out", data_out, 8'h55);

    // ---- pop on empty with push: read ignored, write accepted, error
    cyc(1'b1, 8'h3C, 1'b1);
    chk("uflow.valid_out", {7'd0, valid_out}, 8'h00);
    chk("uflow.error", {7'd0, error}, 8'h01);
    chk("uflow.empty", {7'd0, empty}, 8'h00);
    cyc(1'b0, 8'h00, 1'b1);
    chk("uflow.next_data", data_out, 8'h3C);
    chk("uflow.next_valid", {7'd0, valid_out}, 8'h01);
    chk("uflow.next_error", {7'd0, error}, {7'd0, c_sticky});

    // ---- pointer wrap: steady count of 1 over 10 push+pop cycles
    cyc(1'b1, 8'h10, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 8'h10 + 8'(i), 1'b1);
      exp_word = 8'h10 + 8'(i - 1);
      chk("wrap.data_out", data_out, exp_word);
      chk("wrap.valid_out", {7'd0, valid_out}, 8'h01);
      chk("wrap.almost_empty", {7'd0, almost_empty}, 8'h01);
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("wrap.last_data", data_out, 8'h1A);
    chk("wrap.empty", {7'd0, empty}, 8'h01);

    // ---- asynchronous reset mid-cycle with count = 2
    cyc(1'b1, 8'h61, 1'b0);
    cyc(1'b1, 8'h62, 1'b0);
    cyc(1'b1, 8'h63, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("prerst.data_out", data_out, 8'h61);
    chk("prerst.valid_out", {7'd0, valid_out}, 8'h01);
    push = 1'b0;
    pop  = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    chk("arst.data_out", data_out, 8'h00);
    chk("arst.valid_out", {7'd0, valid_out}, 8'h00);
    chk("arst.error", {7'd0, error}, 8'h00);
    chk_flags("arst", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset_L = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    chk("postrst.valid_out", {7'd0, valid_out}, 8'h00);
    chk("postrst.error", {7'd0, error}, 8'h01);
    chk("postrst.empty", {7'd0, empty}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fifo_8b
`default_nettype wire
